// File: rtl/equality_comparator.sv
// Unsigned WIDTH-bit equality compare: combinational result plus registered, valid-qualified stream with match statistics.
// Define EQUALITY_COMPARATOR_MASK_EN to add a per-bit compare mask port.
module equality_comparator #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef EQUALITY_COMPARATOR_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  input  logic             in_valid,
  input  logic             clr,
  output logic             equal,
  output logic             eq_valid,
  output logic             eq_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] cmp_cnt,
  output logic             mismatch_seen
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] bit_eq;

  // Per-bit XNOR; a masked-off bit always reads as matching.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
`ifdef EQUALITY_COMPARATOR_MASK_EN
      assign bit_eq[gi] = ~(a[gi] ^ b[gi]) | ~mask[gi];
`else
      assign bit_eq[gi] = ~(a[gi] ^ b[gi]);
`endif
    end
  endgenerate

  assign equal = &bit_eq;

  logic             eq_valid_reg, eq_valid_next;
  logic             eq_q_reg, eq_q_next;
  logic [CNT_W-1:0] match_cnt_reg, match_cnt_next;
  logic [CNT_W-1:0] cmp_cnt_reg, cmp_cnt_next;
  logic             mismatch_seen_reg, mismatch_seen_next;

  always_comb begin
    eq_valid_next      = in_valid;
    eq_q_next          = in_valid ? equal : eq_q_reg;
    match_cnt_next     = match_cnt_reg;
    cmp_cnt_next       = cmp_cnt_reg;
    mismatch_seen_next = mismatch_seen_reg;
    // Clear takes priority, so a compare arriving with clr is not counted.
    if (clr) begin
      match_cnt_next     = '0;
      cmp_cnt_next       = '0;
      mismatch_seen_next = 1'b0;
    end else if (in_valid) begin
      if (cmp_cnt_reg != CNT_MAX) begin
        cmp_cnt_next = cmp_cnt_reg + 1'b1;
      end
      if (equal) begin
        if (match_cnt_reg != CNT_MAX) begin
          match_cnt_next = match_cnt_reg + 1'b1;
        end
      end else begin
        mismatch_seen_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_valid_reg      <= 1'b0;
      eq_q_reg          <= 1'b0;
      match_cnt_reg     <= '0;
      cmp_cnt_reg       <= '0;
      mismatch_seen_reg <= 1'b0;
    end else begin
      eq_valid_reg      <= eq_valid_next;
      eq_q_reg          <= eq_q_next;
      match_cnt_reg     <= match_cnt_next;
      cmp_cnt_reg       <= cmp_cnt_next;
      mismatch_seen_reg <= mismatch_seen_next;
    end
  end

  assign eq_valid      = eq_valid_reg;
  assign eq_q          = eq_q_reg;
  assign match_cnt     = match_cnt_reg;
  assign cmp_cnt       = cmp_cnt_reg;
  assign mismatch_seen = mismatch_seen_reg;

endmodule

// File: tb/tb_equality_comparator.sv
// Directed bench for equality_comparator: combinational checks inline, registered stream checked by a queue-based monitor.
module tb_equality_comparator;

  localparam int WIDTH = 5;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
`ifdef EQUALITY_COMPARATOR_MASK_EN
  logic [WIDTH-1:0] mask = '1;
`endif
  logic             in_valid = 1'b0;
  logic             clr = 1'b0;
  logic             equal;
  logic             eq_valid;
  logic             eq_q;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] cmp_cnt;
  logic             mismatch_seen;

  int checks = 0;
  int errors = 0;
  int sb[$];

  equality_comparator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a),
    .b            (b),
`ifdef EQUALITY_COMPARATOR_MASK_EN
    .mask         (mask),
`endif
    .in_valid     (in_valid),
    .clr          (clr),
    .equal        (equal),
    .eq_valid     (eq_valid),
    .eq_q         (eq_q),
    .match_cnt    (match_cnt),
    .cmp_cnt      (cmp_cnt),
    .mismatch_seen(mismatch_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Apply one cycle of stimulus just after a rising edge; queue the expected eq_q when valid.
  task automatic drive(input int va, input int vb, input bit vv, input bit vc, input int exp_eq);
    @(posedge clk);
    #1;
    a        = WIDTH'(va);
    b        = WIDTH'(vb);
    in_valid = vv;
    clr      = vc;
    if (vv) sb.push_back(exp_eq);
  endtask

  task automatic comb(input int va, input int vb, input int exp_eq);
    a = WIDTH'(va);
    b = WIDTH'(vb);
    #1;
    check($sformatf("equal(%0d,%0d)", va, vb), int'(equal), exp_eq);
  endtask

  // Monitor: every presented result is compared against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && eq_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL eq_stream: got eq_valid with eq_q=%0d expected no output", eq_q);
      end else begin
        check("eq_stream", int'(eq_q), sb.pop_front());
      end
    end
  end

  initial begin
    logic [5:0] wide63;
    wide63 = 6'd63;

    #1;
    check("rst_eq_valid", int'(eq_valid), 0);
    check("rst_eq_q", int'(eq_q), 0);
    check("rst_match_cnt", int'(match_cnt), 0);
    check("rst_cmp_cnt", int'(cmp_cnt), 0);
    check("rst_mismatch", int'(mismatch_seen), 0);

    comb(0, 0, 1);
    comb(1, 2, 0);
    comb(2, 1, 0);
    comb(3, 5, 0);
    comb(0, 8, 0);
    comb(1, 1, 1);
    comb(3, 3, 1);
    comb(5, 5, 1);
    a = WIDTH'(wide63);
    b = WIDTH'(wide63);
    #1;
    check("equal(63,63)", int'(equal), 1);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        comb(i, j, (i == j) ? 1 : 0);
      end
    end

`ifdef EQUALITY_COMPARATOR_MASK_EN
    mask = 5'b00011;
    comb(5'b10101, 5'b01101, 1);
    mask = 5'b11111;
    comb(5'b10101, 5'b01101, 0);
    mask = 5'b00000;
    comb(5'b11111, 5'b00000, 1);
    mask = 5'b11111;
`endif

    a = '0;
    b = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(4, 4, 1'b1, 1'b0, 1);
    drive(4, 5, 1'b1, 1'b0, 0);
    drive(0, 0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    check("idle_eq_valid", int'(eq_valid), 0);
    check("idle_eq_q_hold", int'(eq_q), 0);
    check("match_cnt_after2", int'(match_cnt), 1);
    check("cmp_cnt_after2", int'(cmp_cnt), 2);
    check("mismatch_after2", int'(mismatch_seen), 1);

    drive(7, 7, 1'b1, 1'b1, 1);
    drive(0, 0, 1'b0, 1'b0, 0);
    #1;
    check("clr_match_cnt", int'(match_cnt), 0);
    check("clr_cmp_cnt", int'(cmp_cnt), 0);
    check("clr_mismatch", int'(mismatch_seen), 0);

    for (int i = 0; i < 260; i++) begin
      drive(i % 32, i % 32, 1'b1, 1'b0, 1);
    end
    drive(0, 0, 1'b0, 1'b0, 0);
    #1;
    check("sat_match_cnt", int'(match_cnt), 255);
    check("sat_cmp_cnt", int'(cmp_cnt), 255);
    check("sat_mismatch", int'(mismatch_seen), 0);

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_eq_valid", int'(eq_valid), 0);
    check("async_rst_eq_q", int'(eq_q), 0);
    check("async_rst_match_cnt", int'(match_cnt), 0);
    check("async_rst_cmp_cnt", int'(cmp_cnt), 0);
    check("async_rst_mismatch", int'(mismatch_seen), 0);
    check("sb_drained", sb.size(), 0);

    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/equality_comparator.md
Name: equality_comparator

Overview:
- Parameterised unsigned equality comparator between two WIDTH-bit operands.
- Provides an immediate combinational result plus a registered, valid-qualified result stream with match statistics.
- Used as a leaf compare primitive in datapath and self-check logic; the combinational path is usable with no clock activity.

Parameters:
- WIDTH, 5, operand width in bits.
- CNT_W, 8, width of the match and compare counters.

Ports:
- clk  in  1  rising-edge clock for all registered outputs.
- rst_n  in  1  asynchronous active-low reset.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- in_valid  in  1  qualifies a/b for the registered path.
- clr  in  1  synchronous clear of statistics; does not affect equal/eq_q/eq_valid.
- equal  out  1  combinational: 1 iff a == b.
- eq_valid  out  1  registered in_valid, 1-cycle latency.
- eq_q  out  1  registered equal, captured when in_valid=1.
- match_cnt  out  CNT_W  number of valid compares with equal=1.
- cmp_cnt  out  CNT_W  number of valid compares.
- mismatch_seen  out  1  sticky: set on any valid compare with equal=0.

Behaviour:
- equal:
  - Purely combinational, no clock or reset dependency.
  - Bitwise XNOR of a and b reduced by AND.
  - Settles within the same delta/timestep as an input change.
- X/Z on any operand bit is not required to produce a defined equal.
- Operands are exactly WIDTH bits. Wider values driven by the instantiating scope truncate to the low WIDTH bits before comparison; 63 vs 63 at WIDTH=5 compares 31 vs 31 and gives equal=1.
- Reset (rst_n=0, asynchronous assert; deassert sampled on the next clk edge):
  - eq_valid=0, eq_q=0, match_cnt=0, cmp_cnt=0, mismatch_seen=0.
- Each rising clk with rst_n=1:
  - eq_valid <= in_valid.
  - If in_valid=1: eq_q <= equal. Otherwise eq_q holds its previous value.
- Statistics update on the same edge:
  - If clr=1: match_cnt=0, cmp_cnt=0, mismatch_seen=0. clr wins over a simultaneous in_valid, so that cycle's compare is not counted.
  - Else if in_valid=1: cmp_cnt+1; match_cnt+1 when equal=1; mismatch_seen set to 1 when equal=0.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-operation clears all registered state immediately; equal is unaffected.
- No backpressure: every cycle with in_valid=1 is accepted.

Optional Feature:
- Macro: EQUALITY_COMPARATOR_MASK_EN.
- When defined:
  - Adds input port mask [WIDTH-1:0], placed after b.
  - equal = 1 iff ((a ^ b) & mask) == 0. Bits with mask=0 are don't-care.
  - mask = all-zero gives equal=1 for any operands.
  - The registered path and statistics use this masked equal.
- When not defined:
  - No mask port.
  - Full-width compare exactly as in Behaviour.

Test Plan:
- Combinational, no clock, 1 time unit settle after each change:
  - (0,0) -> equal=1.
  - (1,2), (2,1), (3,5), (0,8) -> equal=0.
  - (1,1), (3,3), (5,5) -> equal=1.
  - a=b=63 driven into the 5-bit ports -> equal=1.
- Exhaustive sweep of a,b in 0..3 (16 pairs) -> equal == (a==b) for each pair.
- Registered path, clocked after reset release:
  - Drive in_valid=1 with (4,4), then (4,5), then in_valid=0.
  - Required: eq_valid/eq_q = 1/1, then 1/0, then 0/0 (eq_q holds 0).
  - After these: match_cnt=1, cmp_cnt=2, mismatch_seen=1.
- clr=1 together with in_valid=1 and (7,7) -> next cycle match_cnt=0, cmp_cnt=0, mismatch_seen=0.
- Saturation: 260 consecutive valid equal compares at CNT_W=8 -> match_cnt=cmp_cnt=255. Then assert rst_n=0 between clock edges -> all registered outputs 0 immediately.
- With EQUALITY_COMPARATOR_MASK_EN:
  - mask=5'b00011, a=5'b10101, b=5'b01101 -> equal=1.
  - mask=5'b11111, same operands -> equal=0.
